sram_bank_buf: RTL and testbench
================================

Name: sram_bank_buf

Overview:
- Next-generation on-chip buffer for the LeNet accelerator's feature maps and weights.
- Single-port-write / single-port-read synchronous SRAM with per-byte write enables, configurable read latency and a `rd_valid` strobe.
- Defined read-during-write semantics.
- A sequential init sweep replaces reset-time array clearing, so the array maps to real RAM macros.

Parameters:
- DATA_WIDTH, 16, word width; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, lane width for byte enables; NUM_BE = DATA_WIDTH/BYTE_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = return old data, 1 = write-through (return merged new data).
- INIT_VALUE, 0, word value written to every location by the init sweep.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- csen  in  1  chip select; high active, gates both ports
- clr  in  1  single-cycle pulse; restarts the init sweep at runtime
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  NUM_BE  byte enables; bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data, registered
- rd_valid  out  1  one-cycle strobe; rd_data is valid while it is high
- rd_err  out  1  parity error qualifier for rd_data; see Optional Feature
- busy  out  1  high while the init sweep runs

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- Reset response (rst=1 at a clk edge), effective the next cycle:
  - state=INIT, sweep counter=0, busy=1
  - rd_valid=0, rd_err=0, rd_data=0
  - read pipeline flushed
  - array contents are not touched by reset itself.
- INIT state:
  - Each cycle write INIT_VALUE (all lanes) to mem[cnt], then cnt++.
  - After writing address DEPTH-1, go to RUN on the next edge; busy=0 from that cycle.
  - Sweep takes exactly DEPTH cycles.
  - wr_en, rd_en and clr are ignored; no new reads are accepted.
- RUN state:
  - A write is performed when csen & wr_en. Only lanes with wr_be[i]=1 update; wr_be=0 is a no-op.
  - A read is accepted when csen & rd_en.
  - For a read accepted at edge T: rd_data is updated and rd_valid=1 for exactly one cycle after edge T+RD_LATENCY-1.
    - RD_LATENCY=1: same timing as a plain synchronous RAM.
    - RD_LATENCY=2: adds one output register stage.
  - rd_data holds its last value when rd_valid=0.
  - Back-to-back reads sustain 1 read/cycle at either latency.
- Same-cycle read/write to the same address:
  - RDW_MODE=0: the read returns pre-write contents.
  - RDW_MODE=1: the read returns the merged word (enabled lanes from wr_data, others from memory).
  - Different addresses: no interaction.
- clr=1 in RUN:
  - Next state is INIT with cnt=0 and busy=1 next cycle.
  - A write or read presented in the same cycle as clr is dropped.
  - Reads accepted before clr still complete through the pipeline with their sampled data.
- Reset during INIT restarts the sweep at address 0.
- clr held high: treated as a pulse; only re-triggers from RUN.
- csen=0: no writes, no new reads; in-flight reads still complete.
- Address wrap: none. Addresses are full-range and every value is legal.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- With the macro:
  - Each word stores NUM_BE extra even-parity bits, one per lane, computed on write and by the sweep.
  - On read, parity is recomputed. rd_err=1 coincident with rd_valid if any lane mismatches.
  - A write-through result in RDW_MODE=1 uses freshly computed parity.
- Without the macro: no parity storage; rd_err is tied to 0.

Decomposition:
- Package sram_pkg holds:
  - state encoding (ST_INIT, ST_RUN)
  - RDW mode constants (RDW_READ_OLD=0, RDW_WRITE_THROUGH=1)
  - a lane-parity function
  - an elaboration check that DATA_WIDTH % BYTE_WIDTH == 0 and RD_LATENCY is in {1,2}.
- Sub-module sram_rd_pipe: the parametrised data/valid/err delay line used for RD_LATENCY stages.

Test Plan:
- Reset, then hold rst=0 -> busy=1 for exactly 256 cycles (default params); afterwards reading addr 0x00 and 0xFF returns 0x0000 with rd_valid after RD_LATENCY.
- Write 0xABCD to 0x10 with wr_be=2'b11, then write 0x1234 with wr_be=2'b01 -> read of 0x10 returns 0xAB34.
- RDW_MODE=0: mem[0x20]=0x5555; same cycle write 0xAAAA and read 0x20 -> 0x5555 returned; next read returns 0xAAAA. RDW_MODE=1: the same-cycle read returns 0xAAAA.
- RD_LATENCY=2: reads to 0x01, 0x02, 0x03 on consecutive cycles -> rd_valid high 3 consecutive cycles, starting 2 cycles after the first request, data in order.
- clr pulse one cycle after a read request to 0x30 (holding 0x7777) -> the read still returns 0x7777; busy=1 for 256 cycles; then 0x30 reads INIT_VALUE.
- With SRAM_PARITY_EN: normal write/read -> rd_err=0. Force-flip a stored data bit of 0x40 -> rd_err=1 in the same cycle as rd_valid.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and helpers for the sram_bank_buf feature-map/weight buffer.
// Parity support in the top level is enabled by defining SRAM_PARITY_EN.
package sram_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int RDW_READ_OLD      = 0;
  localparam int RDW_WRITE_THROUGH = 1;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int MAX_LANE_W = 64;

  // Even parity: the stored bit makes the lane plus parity carry an even number of ones.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
    return ^lane;
  endfunction

  function automatic bit params_ok(input int data_w, input int byte_w, input int rd_lat);
    return (byte_w > 0) && (byte_w <= MAX_LANE_W) && (data_w % byte_w == 0) &&
           (rd_lat == 1 || rd_lat == 2);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return delay line: STAGES registers of data/valid/err; data holds while idle.
module sram_rd_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         err_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         err_o
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] err_q;
  logic [W-1:0]      data_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= valid_i & err_i;
      if (valid_i) data_q[0] <= data_i;
      for (int s = 1; s < STAGES; s++) begin
        valid_q[s] <= valid_q[s-1];
        err_q[s]   <= valid_q[s-1] & err_q[s-1];
        if (valid_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign err_o   = err_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/sram_bank_buf.sv
// Byte-enabled 1W/1R synchronous buffer with init sweep and configurable read latency.
// Define SRAM_PARITY_EN to store per-lane even parity and report it on rd_err.
module sram_bank_buf
  import sram_pkg::*;
#(
  parameter int                  DATA_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  BYTE_WIDTH = 8,
  parameter int                  RD_LATENCY = 1,
  parameter int                  RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             csen,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_err,
  output logic                             busy
);

  localparam int NUM_BE = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
`ifdef SRAM_PARITY_EN
  localparam int MEM_W  = DATA_WIDTH + NUM_BE;
`else
  localparam int MEM_W  = DATA_WIDTH;
`endif

  if (!params_ok(DATA_WIDTH, BYTE_WIDTH, RD_LATENCY)) begin : g_bad_params
    $error("sram_bank_buf: DATA_WIDTH must be a multiple of BYTE_WIDTH and RD_LATENCY must be 1 or 2");
  end

  logic [MEM_W-1:0]      mem_q [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_q;

  logic                  run;
  logic                  clr_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [MEM_W-1:0]      init_word;
  logic [MEM_W-1:0]      wr_word;
  logic [MEM_W-1:0]      rd_word;
  logic                  rd_err_c;

  // clr is edge-detected so a held level restarts the sweep only once; ops in that cycle are dropped.
  assign run      = (state_q == ST_RUN);
  assign clr_fire = run & clr & ~clr_q;
  assign wr_fire  = run & csen & wr_en & ~clr_fire;
  assign rd_fire  = run & csen & rd_en & ~clr_fire;
  assign busy     = (state_q == ST_INIT);

  always_comb begin
    init_word                   = '0;
    init_word[DATA_WIDTH-1:0]   = INIT_VALUE;
    wr_word                     = '0;
    wr_word[DATA_WIDTH-1:0]     = wr_data;
`ifdef SRAM_PARITY_EN
    for (int i = 0; i < NUM_BE; i++) begin
      init_word[DATA_WIDTH+i] = lane_parity(MAX_LANE_W'(INIT_VALUE[i*BYTE_WIDTH +: BYTE_WIDTH]));
      wr_word[DATA_WIDTH+i]   = lane_parity(MAX_LANE_W'(wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]));
    end
`endif
    rd_word = mem_q[rd_addr];
    if (RDW_MODE == RDW_WRITE_THROUGH && wr_fire && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NUM_BE; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SRAM_PARITY_EN
          rd_word[DATA_WIDTH+i] = wr_word[DATA_WIDTH+i];
`endif
        end
      end
    end
    rd_err_c = 1'b0;
`ifdef SRAM_PARITY_EN
    for (int i = 0; i < NUM_BE; i++) begin
      if (lane_parity(MAX_LANE_W'(rd_word[i*BYTE_WIDTH +: BYTE_WIDTH])) != rd_word[DATA_WIDTH+i])
        rd_err_c = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr_fire) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr;
    end
  end

  // Array has no reset so it maps onto a RAM macro; the sweep does the clearing.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_INIT) begin
      mem_q[cnt_q] <= init_word;
    end else if (!rst && wr_fire) begin
      for (int i = 0; i < NUM_BE; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SRAM_PARITY_EN
          mem_q[wr_addr][DATA_WIDTH+i] <= wr_word[DATA_WIDTH+i];
`endif
        end
      end
    end
  end

  // Return path: rd_valid pulses once per accepted read, RD_LATENCY edges after acceptance.
  sram_rd_pipe #(
    .W      (DATA_WIDTH),
    .STAGES (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_fire),
    .data_i  (rd_word[DATA_WIDTH-1:0]),
    .err_i   (rd_err_c),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .err_o   (rd_err)
  );

endmodule

// File: tb/tb_sram_bank_buf.sv
// Directed bench: three buffers share stimulus (default, RD_LATENCY=2, RDW_MODE=1).
module tb_sram_bank_buf;

  localparam int DW  = 16;
  localparam int AW  = 8;
  localparam int NBE = 2;

  logic          clk = 1'b0;
  logic          rst, csen, clr, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [NBE-1:0] wr_be;

  logic [DW-1:0] rd_data_a, rd_data_b, rd_data_c;
  logic          rd_valid_a, rd_valid_b, rd_valid_c;
  logic          rd_err_a, rd_err_b, rd_err_c;
  logic          busy_a, busy_b, busy_c;

  int checks   = 0;
  int failures = 0;
  int n;
  int vseen;

  always #5 clk = ~clk;

  sram_bank_buf u_dut (
    .clk(clk), .rst(rst), .csen(csen), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_err(rd_err_a), .busy(busy_a)
  );

  sram_bank_buf #(.RD_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .csen(csen), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_err(rd_err_b), .busy(busy_b)
  );

  sram_bank_buf #(.RDW_MODE(1)) u_dut_wt (
    .clk(clk), .rst(rst), .csen(csen), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_c), .rd_valid(rd_valid_c), .rd_err(rd_err_c), .busy(busy_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NBE-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check_eq({tag, "_a_vld"}, 32'(rd_valid_a), 32'd1);
    check_eq({tag, "_a_dat"}, 32'(rd_data_a), 32'(exp));
    check_eq({tag, "_a_err"}, 32'(rd_err_a), 32'd0);
    check_eq({tag, "_c_dat"}, 32'(rd_data_c), 32'(exp));
    check_eq({tag, "_b_early"}, 32'(rd_valid_b), 32'd0);
    tick();
    check_eq({tag, "_b_vld"}, 32'(rd_valid_b), 32'd1);
    check_eq({tag, "_b_dat"}, 32'(rd_data_b), 32'(exp));
    check_eq({tag, "_a_strobe"}, 32'(rd_valid_a), 32'd0);
    check_eq({tag, "_a_hold"}, 32'(rd_data_a), 32'(exp));
  endtask

  task automatic wait_sweep(output int ticks);
    ticks = 0;
    while (busy_a === 1'b1 && ticks < 1000) begin
      tick();
      ticks++;
    end
  endtask

  initial begin
    rst = 1'b1; csen = 1'b1;
    idle();
    wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
    tick();
    tick();
    check_eq("rst_busy", 32'(busy_a), 32'd1);
    check_eq("rst_vld", 32'(rd_valid_a), 32'd0);
    check_eq("rst_dat_a", 32'(rd_data_a), 32'd0);
    check_eq("rst_dat_b", 32'(rd_data_b), 32'd0);
    check_eq("rst_err", 32'(rd_err_a), 32'd0);

    // Reset part-way through a sweep restarts it from address 0.
    rst = 1'b0;
    repeat (50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rerst_busy", 32'(busy_a), 32'd1);

    // Traffic during the sweep must be ignored.
    wr_en = 1'b1; wr_addr = 8'h05; wr_data = 16'hDEAD; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 8'h05;
    n = 0; vseen = 0;
    while (busy_a === 1'b1 && n < 1000) begin
      tick();
      n++;
      if (rd_valid_a || rd_valid_b || rd_valid_c) vseen++;
    end
    idle();
    check_eq("sweep_len", 32'(n), 32'd256);
    check_eq("sweep_no_rd", 32'(vseen), 32'd0);
    check_eq("sweep_busy_b", 32'(busy_b), 32'd0);
    check_eq("sweep_busy_c", 32'(busy_c), 32'd0);

    read_check("init_00", 8'h00, 16'h0000);
    read_check("init_ff", 8'hFF, 16'h0000);
    read_check("init_05", 8'h05, 16'h0000);

    write_word(8'h10, 16'hABCD, 2'b11);
    write_word(8'h10, 16'h1234, 2'b01);
    read_check("be_lo", 8'h10, 16'hAB34);
    write_word(8'h10, 16'hFFFF, 2'b00);
    read_check("be_none", 8'h10, 16'hAB34);

    // Same-address read during write.
    write_word(8'h20, 16'h5555, 2'b11);
    write_word(8'h21, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 16'hAAAA; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    idle();
    check_eq("rdw_old_a", 32'(rd_data_a), 32'h5555);
    check_eq("rdw_wt_c", 32'(rd_data_c), 32'hAAAA);
    tick();
    check_eq("rdw_old_b", 32'(rd_data_b), 32'h5555);
    wr_en = 1'b1; wr_addr = 8'h21; wr_data = 16'h2222; wr_be = 2'b01;
    rd_en = 1'b1; rd_addr = 8'h21;
    tick();
    idle();
    check_eq("rdw_part_a", 32'(rd_data_a), 32'h1111);
    check_eq("rdw_part_c", 32'(rd_data_c), 32'h1122);
    tick();
    read_check("rdw_after20", 8'h20, 16'hAAAA);
    read_check("rdw_after21", 8'h21, 16'h1122);
    wr_en = 1'b1; wr_addr = 8'h22; wr_data = 16'h9999; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 8'h20;
    tick();
    idle();
    check_eq("rdw_diff_c", 32'(rd_data_c), 32'hAAAA);
    tick();

    // Back-to-back reads at both latencies.
    write_word(8'h01, 16'h0101, 2'b11);
    write_word(8'h02, 16'h0202, 2'b11);
    write_word(8'h03, 16'h0303, 2'b11);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i + 1);
      tick();
      check_eq("b2b_a_vld", 32'(rd_valid_a), 32'd1);
      check_eq("b2b_a_dat", 32'(rd_data_a), 32'(16'h0101 * (i + 1)));
      check_eq("b2b_b_vld", 32'(rd_valid_b), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check_eq("b2b_b_dat", 32'(rd_data_b), 32'(16'h0101 * i));
    end
    idle();
    tick();
    check_eq("b2b_b_last_vld", 32'(rd_valid_b), 32'd1);
    check_eq("b2b_b_last_dat", 32'(rd_data_b), 32'h0303);
    check_eq("b2b_a_done", 32'(rd_valid_a), 32'd0);
    check_eq("b2b_a_hold", 32'(rd_data_a), 32'h0303);
    tick();
    check_eq("b2b_b_done", 32'(rd_valid_b), 32'd0);
    check_eq("b2b_b_hold", 32'(rd_data_b), 32'h0303);

    // Chip select gates new work but not in-flight reads.
    csen = 1'b0;
    wr_en = 1'b1; wr_addr = 8'h50; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 8'h50;
    tick();
    idle();
    check_eq("cs_no_rd", 32'(rd_valid_a), 32'd0);
    csen = 1'b1;
    tick();
    read_check("cs_no_wr", 8'h50, 16'h0000);
    rd_en = 1'b1; rd_addr = 8'h02;
    tick();
    csen = 1'b0;
    tick();
    rd_en = 1'b0;
    check_eq("cs_inflight_vld", 32'(rd_valid_b), 32'd1);
    check_eq("cs_inflight_dat", 32'(rd_data_b), 32'h0202);
    csen = 1'b1;
    tick();

    // clr after an accepted read: the read completes, a read with clr is dropped.
    write_word(8'h30, 16'h7777, 2'b11);
    rd_en = 1'b1; rd_addr = 8'h30;
    tick();
    check_eq("clr_pre_a", 32'(rd_data_a), 32'h7777);
    clr = 1'b1;
    tick();
    idle();
    check_eq("clr_busy", 32'(busy_a), 32'd1);
    check_eq("clr_drop_a", 32'(rd_valid_a), 32'd0);
    check_eq("clr_pipe_b_vld", 32'(rd_valid_b), 32'd1);
    check_eq("clr_pipe_b_dat", 32'(rd_data_b), 32'h7777);
    wait_sweep(n);
    check_eq("clr_sweep_len", 32'(n), 32'd256);
    read_check("clr_30", 8'h30, 16'h0000);
    read_check("clr_10", 8'h10, 16'h0000);

`ifdef SRAM_PARITY_EN
    write_word(8'h40, 16'h0F0F, 2'b11);
    read_check("par_ok", 8'h40, 16'h0F0F);
    u_dut.mem_q[64] = u_dut.mem_q[64] ^ 18'h1;
    rd_en = 1'b1; rd_addr = 8'h40;
    tick();
    rd_en = 1'b0;
    check_eq("par_bad_vld", 32'(rd_valid_a), 32'd1);
    check_eq("par_bad_err", 32'(rd_err_a), 32'd1);
    check_eq("par_bad_dat", 32'(rd_data_a), 32'h0F0E);
    tick();
    check_eq("par_err_clear", 32'(rd_err_a), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
